// File: rtl/dbus_arbiter.sv
// Two-master arbiter for the single-port data RAM: CPU dbus (m0) and loader/DMA (m1).
// Grants are combinational; read responses come back as a registered rvalid one cycle later.
module dbus_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 32,
  parameter int PRIORITY_M0 = 1,
  parameter int MAX_WAIT    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_wen,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic              m1_req,
  input  logic              m1_wen,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m0_gnt,
  output logic              m1_gnt,
  output logic              m0_rvalid,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_wen,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef struct packed {
    logic              wen;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mreq_t;

  localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

  mreq_t      m0_r, m1_r, sel;
  logic [1:0] gnt;
  logic [1:0] rvalid;
  logic [3:0] wait_cnt;
  logic       last;
  logic       pick_m1;

  assign m0_r = '{wen: m0_wen, addr: m0_addr, wdata: m0_wdata};
  assign m1_r = '{wen: m1_wen, addr: m1_addr, wdata: m1_wdata};

  // Contention winner: starvation guard in priority mode, alternate against last in RR.
  always_comb begin
    pick_m1 = 1'b0;
    gnt     = 2'b00;
    if (PRIORITY_M0 != 0) pick_m1 = (wait_cnt == MAX_W);
    else                  pick_m1 = (last == 1'b0);
    if (rst_n) begin
      if (m0_req && m1_req) gnt = pick_m1 ? 2'b10 : 2'b01;
      else                  gnt = {m1_req, m0_req};
    end
  end

  assign m0_gnt = gnt[0];
  assign m1_gnt = gnt[1];

  always_comb begin
    sel = '0;
    if (gnt[0])      sel = m0_r;
    else if (gnt[1]) sel = m1_r;
  end

  assign ram_addr  = sel.addr;
  assign ram_wdata = sel.wdata;
  assign ram_wen   = sel.wen;
  assign rdata     = ram_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
      last     <= 1'b1;
      rvalid   <= 2'b00;
    end else begin
      rvalid <= gnt & ~{m1_wen, m0_wen};
      if (|gnt) last <= gnt[1];
      if (PRIORITY_M0 != 0 && m1_req && !gnt[1])
        wait_cnt <= (wait_cnt == MAX_W) ? MAX_W : wait_cnt + 4'd1;
      else
        wait_cnt <= '0;
    end
  end

  assign m0_rvalid = rvalid[0];
  assign m1_rvalid = rvalid[1];

endmodule
